// File: rtl/udp_send.sv
// Transmit-side UDP framer: prepends the 8-byte UDP header to an 8-bit payload stream.
// Optional length enforcement (pad short payloads, drop long ones) under `UDP_TX_LEN_CHECK_EN.
module udp_send (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_start_in,
  input  logic [15:0] src_port_in,
  input  logic [15:0] dest_port_in,
  input  logic [15:0] udpdata_length_in,
  output logic        tx_busy_out,
  input  logic [7:0]  udpdata_tdata_in,
  input  logic        udpdata_tvalid_in,
  input  logic        udpdata_tlast_in,
  output logic        udpdata_tready_out,
  output logic [7:0]  udp_axis_tdata_out,
  output logic        udp_axis_tvalid_out,
  output logic        udp_axis_tlast_out,
  input  logic        udp_axis_tready_in,
  output logic        len_err_out
);

  typedef enum logic [2:0] {StIdle, StHdr, StData, StPad, StDrop} state_e;

  state_e      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  hdr_byte;
  logic        pay_beat;

`ifdef UDP_TX_LEN_CHECK_EN
  logic        last_beat;
  assign last_beat = (cnt_q == len_q - 16'd1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      src_q     <= 16'd0;
      dst_q     <= 16'd0;
      len_q     <= 16'd0;
      udp_len_q <= 16'd0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      udp_len_q <= udp_len_d;
      cnt_q     <= cnt_d;
    end
  end

  // Header byte selected by the low counter bits; checksum is always zero.
  always_comb begin
    hdr_byte = 8'h00;
    unique case (cnt_q[2:0])
      3'd0: hdr_byte = src_q[15:8];
      3'd1: hdr_byte = src_q[7:0];
      3'd2: hdr_byte = dst_q[15:8];
      3'd3: hdr_byte = dst_q[7:0];
      3'd4: hdr_byte = udp_len_q[15:8];
      3'd5: hdr_byte = udp_len_q[7:0];
      3'd6: hdr_byte = 8'h00;
      3'd7: hdr_byte = 8'h00;
      default: hdr_byte = 8'h00;
    endcase
  end

  assign tx_busy_out = (state_q != StIdle);
  assign pay_beat    = udpdata_tvalid_in & udpdata_tready_out;

  always_comb begin
    state_d             = state_q;
    src_d               = src_q;
    dst_d               = dst_q;
    len_d               = len_q;
    udp_len_d           = udp_len_q;
    cnt_d               = cnt_q;
    udp_axis_tdata_out  = 8'h00;
    udp_axis_tvalid_out = 1'b0;
    udp_axis_tlast_out  = 1'b0;
    udpdata_tready_out  = 1'b0;
    len_err_out         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tx_start_in) begin
          src_d     = src_port_in;
          dst_d     = dest_port_in;
          len_d     = udpdata_length_in;
          udp_len_d = udpdata_length_in + 16'd8;
          cnt_d     = 16'd0;
          state_d   = StHdr;
        end
      end

      StHdr: begin
        udp_axis_tvalid_out = 1'b1;
        udp_axis_tdata_out  = hdr_byte;
        udp_axis_tlast_out  = (cnt_q[2:0] == 3'd7) && (len_q == 16'd0);
        if (udp_axis_tready_in) begin
          if (cnt_q[2:0] == 3'd7) begin
            cnt_d   = 16'd0;
            state_d = (len_q == 16'd0) ? StIdle : StData;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      StData: begin
        udp_axis_tdata_out  = udpdata_tdata_in;
        udp_axis_tvalid_out = udpdata_tvalid_in;
        udpdata_tready_out  = udp_axis_tready_in;
`ifdef UDP_TX_LEN_CHECK_EN
        udp_axis_tlast_out = last_beat;
        if (pay_beat) begin
          cnt_d = cnt_q + 16'd1;
          if (udpdata_tlast_in && !last_beat) begin
            len_err_out = 1'b1;
            state_d     = StPad;
          end else if (last_beat) begin
            len_err_out = !udpdata_tlast_in;
            state_d     = udpdata_tlast_in ? StIdle : StDrop;
          end
        end
`else
        udp_axis_tlast_out = udpdata_tlast_in;
        if (pay_beat) begin
          cnt_d = cnt_q + 16'd1;
          if (udpdata_tlast_in) state_d = StIdle;
        end
`endif
      end

`ifdef UDP_TX_LEN_CHECK_EN
      StPad: begin
        udp_axis_tvalid_out = 1'b1;
        udp_axis_tlast_out  = last_beat;
        if (udp_axis_tready_in) begin
          cnt_d = cnt_q + 16'd1;
          if (last_beat) state_d = StIdle;
        end
      end

      StDrop: begin
        udpdata_tready_out = 1'b1;
        if (udpdata_tvalid_in && udpdata_tlast_in) state_d = StIdle;
      end
`endif

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/udp_send.md
# udp_send

Transmit-side UDP framer. Accepts a per-frame start command (ports, payload length) and an 8-bit application payload stream, prepends the 8-byte UDP header (source port, destination port, length, checksum = 0x0000), and emits the frame as an 8-bit AXI-Stream toward the IP transmit layer. It is the counterpart of the UDP receive path: its output is exactly what the receiver strips.

## Interface
- No parameters.
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `tx_start_in`  in  1  one-cycle frame request; sampled only when `tx_busy_out`=0.
- `src_port_in`  in  16  UDP source port; latched with `tx_start_in`.
- `dest_port_in`  in  16  UDP destination port; latched with `tx_start_in`.
- `udpdata_length_in`  in  16  payload bytes (0..65527); latched with `tx_start_in`.
- `tx_busy_out`  out  1  high from the cycle after an accepted start until the cycle after the final beat.
- `udpdata_tdata_in`  in  8  payload byte.
- `udpdata_tvalid_in`  in  1  payload valid.
- `udpdata_tlast_in`  in  1  last payload byte.
- `udpdata_tready_out`  out  1  payload ready.
- `udp_axis_tdata_out`  out  8  framed byte to IP layer.
- `udp_axis_tvalid_out`  out  1  framed byte valid.
- `udp_axis_tlast_out`  out  1  last byte of UDP datagram.
- `udp_axis_tready_in`  in  1  IP layer ready.
- `len_err_out`  out  1  one-cycle pulse on length mismatch (only with `UDP_TX_LEN_CHECK_EN`).

## Operation
- States: IDLE, HDR, DATA, PAD, DROP. Reset: state IDLE, all outputs 0, header registers 0.
- IDLE: `tx_start_in`=1 latches ports and length, stores `udp_len = udpdata_length_in + 8` (16-bit, modulo 2^16), clears byte counter, goes to HDR.
- HDR: emits bytes 0..7 MSB first: src[15:8], src[7:0], dst[15:8], dst[7:0], udp_len[15:8], udp_len[7:0], 0x00, 0x00. `udp_axis_tvalid_out`=1; counter advances only on `tvalid_out & tready_in`. Payload `tready_out`=0.
- After byte 7: if payload length = 0, byte 7 carries `tlast_out`=1 and state returns to IDLE; else DATA.
- DATA: combinational pass-through; `tdata_out=tdata_in`, `tvalid_out=tvalid_in`, `tready_out=tready_in`. Payload counter increments per accepted beat.
- Without checking: `tlast_out=tlast_in`; accepted beat with `tlast_in` returns to IDLE.
- With checking: `tlast_out` asserted when counter = length−1 regardless of `tlast_in`. Early `tlast_in` (counter < length−1): that beat forwarded with `tlast_out`=0, `len_err_out` pulses, go PAD. Counter reaches length−1 without `tlast_in`: forward with `tlast_out`=1, pulse `len_err_out`, go DROP.
- PAD: emits 0x00 bytes, `tvalid_out`=1, `tready_out`=0, until length reached; final pad byte has `tlast_out`=1; then IDLE.
- DROP: `tready_out`=1, `tvalid_out`=0; discards payload until accepted `tlast_in`; then IDLE.
- `tx_start_in` while busy is ignored (not queued).

## Timing
- Start accepted in cycle N; first header byte valid in cycle N+1; `tx_busy_out` rises in N+1.
- With `tready_in` held high: header occupies 8 cycles, payload 1 cycle per byte, zero added latency in DATA.
- Return to IDLE the cycle after the final accepted beat; `tx_busy_out` low there; a start that cycle is accepted, giving a one-idle-cycle gap between frames.
- `tvalid_out` in HDR/PAD never deasserts while `tready_in`=0 (AXI-S hold rule); `tdata_out` stable while stalled.
- Reset mid-frame: next cycle IDLE, `tvalid_out`=0, no `tlast_out` emitted; downstream discards partial frame.

## Configuration
- `UDP_TX_LEN_CHECK_EN` defined: counter-based `tlast_out`, PAD/DROP states, `len_err_out` active; datagram byte count always equals `udp_len`.
- Undefined: PAD/DROP absent, `tlast_out` follows `tlast_in`, `len_err_out` tied 0; header length field trusted as given.

## Test plan
- Start src=0x1234, dst=0x5678, len=4, payload 0xA1..0xA4, ready high -> output 12 34 56 78 00 0C 00 00 A1 A2 A3 A4, tlast on A4, 12 consecutive valid cycles.
- len=0 start -> 8 header bytes, length field 0x0008, tlast on byte 7, payload tready never asserted.
- Same as first with `tready_in` toggling 1/0 every cycle -> identical byte sequence, data stable during stalls, busy low one cycle after A4.
- `UDP_TX_LEN_CHECK_EN`, len=4, payload tlast on 2nd byte -> bytes A1 A2 00 00, tlast on final 00, one `len_err_out` pulse.
- `UDP_TX_LEN_CHECK_EN`, len=2, payload 5 bytes -> A1 A2 with tlast on A2, bytes 3..5 consumed and dropped, one `len_err_out` pulse.
- Reset asserted during 3rd header byte -> next cycle tvalid_out=0, busy=0; following start produces a clean full frame.
